// File: rtl/jtframe_neptuno_joyemu_if.sv
// Serial joystick link between a Neptuno-style reader (master) and the
// shift-register emulator (slave), plus the pad inputs and frame status.
interface jtframe_neptuno_joyemu_if;
   logic       joy_clk;
   logic       joy_load;
   logic       joy_data;
   logic [5:0] joy1;
   logic [5:0] joy2;
   logic [4:0] bit_cnt;
   logic       frame_done;

   modport master (
      output joy_clk, joy_load, joy1, joy2,
      input  joy_data, bit_cnt, frame_done
   );

   modport slave (
      input  joy_clk, joy_load, joy1, joy2,
      output joy_data, bit_cnt, frame_done
   );
endinterface

// File: rtl/jtframe_neptuno_joyemu.sv
// Emulates the Neptuno external joystick 74x165-style shift chain.
// The host's joy_load/joy_clk lines are synchronised to clk; while load is
// low the register mirrors the pads, once it rises the word is frozen and
// each synchronised joy_clk rise shifts one bit out, back-filling with ones.
module jtframe_neptuno_joyemu #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   jtframe_neptuno_joyemu_if.slave       joy
);

   localparam logic [4:0] LP_FULL = 5'(FRAME_BITS);

   logic [SYNC_STAGES-1:0] r_clkSync;
   logic [SYNC_STAGES-1:0] r_loadSync;
   logic                   r_clkPrev;
   logic [FRAME_BITS-1:0]  r_shift;
   logic [4:0]             r_bitCnt;
   logic                   r_frameDone;

   logic                   w_clkRise;
   logic                   w_loading;
   logic [FRAME_BITS-1:0]  w_word;

   // Synchronise the asynchronous host lines; everything resets high so that
   // leaving reset never looks like a joy_clk rise or a load pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clkSync  <= '1;
         r_loadSync <= '1;
         r_clkPrev  <= 1'b1;
      end else begin
         r_clkSync[0]  <= joy.joy_clk;
         r_loadSync[0] <= joy.joy_load;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_clkSync[i]  <= r_clkSync[i-1];
            r_loadSync[i] <= r_loadSync[i-1];
         end
         r_clkPrev <= r_clkSync[SYNC_STAGES-1];
      end
   end

   assign w_clkRise = r_clkSync[SYNC_STAGES-1] & ~r_clkPrev;
   assign w_loading = ~r_loadSync[SYNC_STAGES-1];

   // Build the active-low frame word: first bit out is up1, then down, left,
   // right, fire1, fire2, two idle ones, the same for pad 2, ones after that.
   always_comb begin
      w_word        = '1;
      w_word[5:0]   = ~{joy.joy1[5], joy.joy1[4], joy.joy1[0],
                        joy.joy1[1], joy.joy1[2], joy.joy1[3]};
      w_word[13:8]  = ~{joy.joy2[5], joy.joy2[4], joy.joy2[0],
                        joy.joy2[1], joy.joy2[2], joy.joy2[3]};
   end

   // Load keeps the register transparent and wins over a coincident clock
   // edge; in shift mode each edge moves one bit toward joy_data and the
   // counter saturates, pulsing frame_done only on the final frame bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '1;
         r_bitCnt    <= 5'd0;
         r_frameDone <= 1'b0;
      end else if (w_loading) begin
         r_shift     <= w_word;
         r_bitCnt    <= 5'd0;
         r_frameDone <= 1'b0;
      end else if (w_clkRise) begin
         r_shift     <= {1'b1, r_shift[FRAME_BITS-1:1]};
         if (r_bitCnt != LP_FULL) begin
            r_bitCnt <= r_bitCnt + 5'd1;
         end
         r_frameDone <= (r_bitCnt == LP_FULL - 5'd1);
      end else begin
         r_frameDone <= 1'b0;
      end
   end

   assign joy.joy_data   = r_shift[0];
   assign joy.bit_cnt    = r_bitCnt;
   assign joy.frame_done = r_frameDone;

endmodule
